// File: rtl/store_buffer_fwd.sv
// In-order store buffer with byte enables and store-to-load forwarding.
// Committed stores queue in a circular array and drain oldest-first to memory.
// Loads that hit a fully-written entry get the data forwarded; loads that hit
// a partially-written youngest entry are flagged to stall.
module store_buffer_fwd #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [DATA_W/8-1:0]        st_be,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic [DATA_W/8-1:0]        mem_be,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic                       fwd_stall,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(BE_W);
    // Word-address mask: drops the byte offset within a data word
    localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << OFF_W;

    logic [ADDR_W-1:0] e_addr [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];
    logic [BE_W-1:0]   e_be   [DEPTH];
    logic              e_vld  [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_r;
    logic              push;
    logic              pop;

    logic              y_found;
    logic [DATA_W-1:0] y_data;
    logic [BE_W-1:0]   y_be;

    // Handshake and head-entry presentation
    always_comb begin
        empty     = (count_r == '0);
        st_ready  = (count_r != CNT_W'(DEPTH));
        mem_valid = !empty;
        push      = st_valid && st_ready;
        pop       = mem_valid && mem_ready;
        count     = count_r;
        mem_addr  = empty ? '0 : e_addr[head];
        mem_data  = empty ? '0 : e_data[head];
        mem_be    = empty ? '0 : e_be[head];
    end

    // Pointer, occupancy and valid-bit update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_vld[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                e_vld[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                e_vld[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; contents are meaningless while the valid bit is clear
    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[tail] <= st_addr;
            e_data[tail] <= st_data;
            e_be[tail]   <= st_be;
        end
    end

    // Youngest-match search: walk oldest to youngest so the last match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        y_found = 1'b0;
        y_data  = '0;
        y_be    = '0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (e_vld[idx] && (((e_addr[idx] ^ ld_addr) & WORD_MASK) == '0)) begin
                y_found = 1'b1;
                y_data  = e_data[idx];
                y_be    = e_be[idx];
            end
        end
        fwd_hit   = y_found && (y_be == '1);
        fwd_stall = y_found && (y_be != '1);
        fwd_data  = fwd_hit ? y_data : '0;
    end

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed, table-driven bench for store_buffer_fwd (DEPTH=4, 32-bit).
// Each vector row is driven at the falling edge; outputs are checked 1ns later,
// i.e. against state built by earlier rows, before this row's push/pop commits.
module tb_store_buffer_fwd;

    logic        clk;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;
    logic [2:0]  count;
    logic        empty;

    int n_chk  = 0;
    int n_fail = 0;

    store_buffer_fwd #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be),
        .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .fwd_stall(fwd_stall), .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [3:0]  sbe;
        logic        mr;
        logic [31:0] la;
        logic [2:0]  ec;
        logic [31:0] ema;
        logic        eh;
        logic        es;
        logic [31:0] ed;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd, logic [3:0] sbe,
                                logic mr, logic [31:0] la, logic [2:0] ec, logic [31:0] ema,
                                logic eh, logic es, logic [31:0] ed);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.sbe = sbe; v.mr = mr; v.la = la;
        v.ec = ec; v.ema = ema; v.eh = eh; v.es = es; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    localparam logic [31:0] NA = 32'h0000_F000;  // load address never stored to

    initial begin
        reset_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        mem_ready = 1'b0; ld_addr = NA;

        // Test 1: fill with mem_ready low, 5th store refused, head held
        vq.push_back(mk(1, 32'h10, 32'hD0D0D0D0, 4'hF, 0, NA,    0, 32'h0,  0, 0, 32'h0));
        vq.push_back(mk(1, 32'h14, 32'hD1D1D1D1, 4'hF, 0, NA,    1, 32'h10, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h18, 32'hD2D2D2D2, 4'hF, 0, NA,    2, 32'h10, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h1C, 32'hD3D3D3D3, 4'hF, 0, NA,    3, 32'h10, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h20, 32'hD4D4D4D4, 4'hF, 0, 32'h1C, 4, 32'h10, 1, 0, 32'hD3D3D3D3));
        vq.push_back(mk(0, 32'h0,  32'h0,        4'h0, 0, 32'h20, 4, 32'h10, 0, 0, 32'h0));
        // Test 2: drain A0..A3; popping entry still forwards
        vq.push_back(mk(0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 4, 32'h10, 1, 0, 32'hD0D0D0D0));
        vq.push_back(mk(0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 3, 32'h14, 0, 0, 32'h0));
        vq.push_back(mk(0, 32'h0, 32'h0, 4'h0, 1, NA,     2, 32'h18, 0, 0, 32'h0));
        vq.push_back(mk(0, 32'h0, 32'h0, 4'h0, 1, NA,     1, 32'h1C, 0, 0, 32'h0));
        vq.push_back(mk(0, 32'h0, 32'h0, 4'h0, 0, NA,     0, 32'h0,  0, 0, 32'h0));
        // Test 3: two entries, then six push+pop cycles across pointer wrap
        vq.push_back(mk(1, 32'h40, 32'hB0, 4'hF, 0, NA, 0, 32'h0,  0, 0, 32'h0));
        vq.push_back(mk(1, 32'h44, 32'hB1, 4'hF, 0, NA, 1, 32'h40, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h48, 32'hB2, 4'hF, 1, NA, 2, 32'h40, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h4C, 32'hB3, 4'hF, 1, NA, 2, 32'h44, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h50, 32'hB4, 4'hF, 1, NA, 2, 32'h48, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h54, 32'hB5, 4'hF, 1, NA, 2, 32'h4C, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h58, 32'hB6, 4'hF, 1, NA, 2, 32'h50, 0, 0, 32'h0));
        vq.push_back(mk(1, 32'h5C, 32'hB7, 4'hF, 1, NA, 2, 32'h54, 0, 0, 32'h0));
        vq.push_back(mk(0, 32'h0,  32'h0,  4'h0, 1, NA, 2, 32'h58, 0, 0, 32'h0));
        vq.push_back(mk(0, 32'h0,  32'h0,  4'h0, 1, NA, 1, 32'h5C, 0, 0, 32'h0));
        vq.push_back(mk(0, 32'h0,  32'h0,  4'h0, 0, NA, 0, 32'h0,  0, 0, 32'h0));
        // Test 4: youngest full match wins; same-cycle push not visible
        vq.push_back(mk(1, 32'h100, 32'h11111111, 4'hF, 0, 32'h102, 0, 32'h0,   0, 0, 32'h0));
        vq.push_back(mk(1, 32'h100, 32'h22222222, 4'hF, 0, 32'h102, 1, 32'h100, 1, 0, 32'h11111111));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 0, 32'h102, 2, 32'h100, 1, 0, 32'h22222222));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h102, 2, 32'h100, 1, 0, 32'h22222222));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h102, 1, 32'h100, 1, 0, 32'h22222222));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 0, 32'h102, 0, 32'h0,   0, 0, 32'h0));
        // Test 5: youngest match partial -> stall; clears after drain
        vq.push_back(mk(1, 32'h200, 32'h33333333, 4'hF, 0, 32'h200, 0, 32'h0,   0, 0, 32'h0));
        vq.push_back(mk(1, 32'h200, 32'h44444444, 4'h3, 0, 32'h200, 1, 32'h200, 1, 0, 32'h33333333));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 0, 32'h200, 2, 32'h200, 0, 1, 32'h0));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h200, 2, 32'h200, 0, 1, 32'h0));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h200, 1, 32'h200, 0, 1, 32'h0));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 0, 32'h200, 0, 32'h0,   0, 0, 32'h0));
        // All-zero byte enables are queued and count as a partial match
        vq.push_back(mk(1, 32'h300, 32'h55555555, 4'h0, 0, 32'h300, 0, 32'h0,   0, 0, 32'h0));
        vq.push_back(mk(0, 32'h0,   32'h0,        4'h0, 0, 32'h300, 1, 32'h300, 0, 1, 32'h0));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_st_ready",  32'(st_ready),  32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr",  mem_addr,       32'h0);
        chk("rst_mem_data",  mem_data,       32'h0);
        chk("rst_mem_be",    32'(mem_be),    32'h0);
        chk("rst_fwd",       {29'd0, fwd_hit, fwd_stall, 1'b0} | fwd_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vq[k]) begin
            @(negedge clk);
            st_valid = vq[k].sv; st_addr = vq[k].sa; st_data = vq[k].sd; st_be = vq[k].sbe;
            mem_ready = vq[k].mr; ld_addr = vq[k].la;
            #1;
            chk($sformatf("v%0d_count", k),     32'(count),     32'(vq[k].ec));
            chk($sformatf("v%0d_st_ready", k),  32'(st_ready),  32'(vq[k].ec != 3'd4));
            chk($sformatf("v%0d_mem_valid", k), 32'(mem_valid), 32'(vq[k].ec != 3'd0));
            chk($sformatf("v%0d_empty", k),     32'(empty),     32'(vq[k].ec == 3'd0));
            chk($sformatf("v%0d_mem_addr", k),  mem_addr,       vq[k].ema);
            chk($sformatf("v%0d_fwd_hit", k),   32'(fwd_hit),   32'(vq[k].eh));
            chk($sformatf("v%0d_fwd_stall", k), 32'(fwd_stall), 32'(vq[k].es));
            chk($sformatf("v%0d_fwd_data", k),  fwd_data,       vq[k].ed);
        end

        // Test 6: three entries queued, asynchronous reset mid-cycle
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h304; st_data = 32'h0; st_be = 4'hF; mem_ready = 1'b0;
        @(negedge clk);
        st_addr = 32'h308;
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("t6_count3",   32'(count),     32'd3);
        chk("t6_mvalid",   32'(mem_valid), 32'd1);
        chk("t6_mem_addr", mem_addr,       32'h300);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_mvalid",  32'(mem_valid), 32'd0);
        chk("t6_rst_count",   32'(count),     32'd0);
        chk("t6_rst_ready",   32'(st_ready),  32'd1);
        chk("t6_rst_memaddr", mem_addr,       32'h0);
        chk("t6_rst_stall",   32'(fwd_stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        st_valid = 1'b1; st_addr = 32'h400; st_data = 32'h66666666; st_be = 4'hF;
        ld_addr = 32'h401;
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("t6_post_count", 32'(count),    32'd1);
        chk("t6_post_addr",  mem_addr,      32'h400);
        chk("t6_post_data",  mem_data,      32'h66666666);
        chk("t6_post_be",    32'(mem_be),   32'hF);
        chk("t6_post_hit",   32'(fwd_hit),  32'd1);
        chk("t6_post_fdata", fwd_data,      32'h66666666);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("t6_drained_empty", 32'(empty),     32'd1);
        chk("t6_drained_hit",   32'(fwd_hit),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
        $fatal(1);
    end

endmodule
